// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: captures decoded instruction state from ID, freezes on
// EX/MEM stalls, turns into a bubble on flushes, and snoops writeback while frozen.
module id_ex_pipeline_register (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_valid,
  input  logic [31:0] ID_pc,
  input  logic [6:0]  ID_opcode,
  input  logic [2:0]  ID_funct3,
  input  logic        ID_funct7b5,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic [4:0]  ID_rd,
  input  logic [31:0] ID_rs1_data,
  input  logic [31:0] ID_rs2_data,
  input  logic [31:0] ID_imm,
  input  logic        ID_regwrite,
  input  logic        ID_memread,
  input  logic        ID_memwrite,
  input  logic        ID_memtoreg,
  input  logic        ID_branch,
  input  logic        ID_alusrc,
  input  logic        EX_stall,
  input  logic        MEM_stall,
  input  logic        EX_flush,
  input  logic [4:0]  WB_rd,
  input  logic [31:0] WB_data,
  input  logic        WB_regwrite,
  output logic        ID_EX_valid,
  output logic [31:0] ID_EX_pc,
  output logic [31:0] ID_EX_imm,
  output logic [31:0] ID_EX_rs1_data,
  output logic [31:0] ID_EX_rs2_data,
  output logic [6:0]  ID_EX_opcode,
  output logic [2:0]  ID_EX_funct3,
  output logic        ID_EX_funct7b5,
  output logic [4:0]  ID_EX_rs1,
  output logic [4:0]  ID_EX_rs2,
  output logic [4:0]  ID_EX_rd,
  output logic        ID_EX_regwrite,
  output logic        ID_EX_memread,
  output logic        ID_EX_memwrite,
  output logic        ID_EX_memtoreg,
  output logic        ID_EX_branch,
  output logic        ID_EX_alusrc,
  output logic        ID_stall,
  output logic        flush_pending,
  output logic [15:0] bubble_count
);

  logic        valid_reg, valid_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] imm_reg, imm_next;
  logic [6:0]  opcode_reg, opcode_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic        funct7b5_reg, funct7b5_next;
  logic [4:0]  rd_reg, rd_next;
  logic [5:0]  ctrl_reg, ctrl_next;
  logic        flush_pending_reg, flush_pending_next;
  logic [15:0] bubble_count_reg, bubble_count_next;

  // Operand lanes: index 0 is rs1, index 1 is rs2
  logic [1:0][4:0]  rs_idx_reg, rs_idx_next;
  logic [1:0][31:0] rs_data_reg, rs_data_next;
  logic [1:0][4:0]  id_rs_idx;
  logic [1:0][31:0] id_rs_data;

  logic take_bubble;
  logic hold;
  logic load_id;
  logic load_real;
  logic loads_bubble;
  logic [5:0] id_ctrl;

  assign id_rs_idx[0]  = ID_rs1;
  assign id_rs_idx[1]  = ID_rs2;
  assign id_rs_data[0] = ID_rs1_data;
  assign id_rs_data[1] = ID_rs2_data;
  assign id_ctrl = {ID_regwrite, ID_memread, ID_memwrite, ID_memtoreg, ID_branch, ID_alusrc};

  // A pending flush is applied on the first unfrozen edge, ahead of any EX stall
  assign take_bubble  = !MEM_stall && (EX_flush || flush_pending_reg);
  assign hold         = MEM_stall || (!take_bubble && EX_stall);
  assign load_id      = !hold && !take_bubble;
  assign load_real    = load_id && ID_valid;
  assign loads_bubble = take_bubble || (load_id && !ID_valid);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      logic wb_hits_id;
      logic wb_hits_ex;

      // x0 never matches, so index-0 reads keep the register-file zero
      assign wb_hits_id = WB_regwrite && (WB_rd != 5'd0) && (WB_rd == id_rs_idx[gi]);
      assign wb_hits_ex = WB_regwrite && (WB_rd != 5'd0) && (WB_rd == rs_idx_reg[gi])
                          && valid_reg;

      assign rs_idx_next[gi] = hold      ? rs_idx_reg[gi] :
                               load_real ? id_rs_idx[gi]  : 5'd0;

      assign rs_data_next[gi] = hold      ? (wb_hits_ex ? WB_data : rs_data_reg[gi]) :
                                load_real ? (wb_hits_id ? WB_data : id_rs_data[gi]) :
                                            32'd0;
    end
  endgenerate

  always_comb begin
    valid_next    = valid_reg;
    pc_next       = pc_reg;
    imm_next      = imm_reg;
    opcode_next   = opcode_reg;
    funct3_next   = funct3_reg;
    funct7b5_next = funct7b5_reg;
    rd_next       = rd_reg;
    ctrl_next     = ctrl_reg;
    if (load_real) begin
      valid_next    = 1'b1;
      pc_next       = ID_pc;
      imm_next      = ID_imm;
      opcode_next   = ID_opcode;
      funct3_next   = ID_funct3;
      funct7b5_next = ID_funct7b5;
      rd_next       = ID_rd;
      ctrl_next     = id_ctrl;
    end else if (loads_bubble) begin
      valid_next    = 1'b0;
      pc_next       = 32'd0;
      imm_next      = 32'd0;
      opcode_next   = 7'd0;
      funct3_next   = 3'd0;
      funct7b5_next = 1'b0;
      rd_next       = 5'd0;
      ctrl_next     = 6'd0;
    end
  end

  always_comb begin
    flush_pending_next = 1'b0;
    if (MEM_stall) begin
      flush_pending_next = flush_pending_reg || EX_flush;
    end
    bubble_count_next = bubble_count_reg;
    if (loads_bubble && (bubble_count_reg != 16'hFFFF)) begin
      bubble_count_next = bubble_count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg         <= 1'b0;
      pc_reg            <= 32'd0;
      imm_reg           <= 32'd0;
      opcode_reg        <= 7'd0;
      funct3_reg        <= 3'd0;
      funct7b5_reg      <= 1'b0;
      rd_reg            <= 5'd0;
      ctrl_reg          <= 6'd0;
      rs_idx_reg        <= '0;
      rs_data_reg       <= '0;
      flush_pending_reg <= 1'b0;
      bubble_count_reg  <= 16'd0;
    end else begin
      valid_reg         <= valid_next;
      pc_reg            <= pc_next;
      imm_reg           <= imm_next;
      opcode_reg        <= opcode_next;
      funct3_reg        <= funct3_next;
      funct7b5_reg      <= funct7b5_next;
      rd_reg            <= rd_next;
      ctrl_reg          <= ctrl_next;
      rs_idx_reg        <= rs_idx_next;
      rs_data_reg       <= rs_data_next;
      flush_pending_reg <= flush_pending_next;
      bubble_count_reg  <= bubble_count_next;
    end
  end

  // IF/ID must advance on a flush cycle so the killed instruction drains
  assign ID_stall = (EX_stall || MEM_stall) && !(EX_flush || flush_pending_reg);

  assign ID_EX_valid    = valid_reg;
  assign ID_EX_pc       = pc_reg;
  assign ID_EX_imm      = imm_reg;
  assign ID_EX_opcode   = opcode_reg;
  assign ID_EX_funct3   = funct3_reg;
  assign ID_EX_funct7b5 = funct7b5_reg;
  assign ID_EX_rd       = rd_reg;
  assign ID_EX_rs1      = rs_idx_reg[0];
  assign ID_EX_rs2      = rs_idx_reg[1];
  assign ID_EX_rs1_data = rs_data_reg[0];
  assign ID_EX_rs2_data = rs_data_reg[1];
  assign {ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite,
          ID_EX_memtoreg, ID_EX_branch, ID_EX_alusrc} = ctrl_reg;
  assign flush_pending  = flush_pending_reg;
  assign bubble_count   = bubble_count_reg;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Scoreboard bench for id_ex_pipeline_register: expected register contents are queued
// when stimulus is driven and compared one edge later.
module tb_id_ex_pipeline_register;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_valid;
  logic [31:0] ID_pc, ID_imm, ID_rs1_data, ID_rs2_data;
  logic [6:0]  ID_opcode;
  logic [2:0]  ID_funct3;
  logic        ID_funct7b5;
  logic [4:0]  ID_rs1, ID_rs2, ID_rd;
  logic        ID_regwrite, ID_memread, ID_memwrite, ID_memtoreg, ID_branch, ID_alusrc;
  logic        EX_stall, MEM_stall, EX_flush;
  logic [4:0]  WB_rd;
  logic [31:0] WB_data;
  logic        WB_regwrite;
  logic        ID_EX_valid;
  logic [31:0] ID_EX_pc, ID_EX_imm, ID_EX_rs1_data, ID_EX_rs2_data;
  logic [6:0]  ID_EX_opcode;
  logic [2:0]  ID_EX_funct3;
  logic        ID_EX_funct7b5;
  logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic        ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_memtoreg;
  logic        ID_EX_branch, ID_EX_alusrc;
  logic        ID_stall, flush_pending;
  logic [15:0] bubble_count;

  id_ex_pipeline_register dut (
    .clk(clk), .rst_n(rst_n), .ID_valid(ID_valid), .ID_pc(ID_pc),
    .ID_opcode(ID_opcode), .ID_funct3(ID_funct3), .ID_funct7b5(ID_funct7b5),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
    .ID_regwrite(ID_regwrite), .ID_memread(ID_memread), .ID_memwrite(ID_memwrite),
    .ID_memtoreg(ID_memtoreg), .ID_branch(ID_branch), .ID_alusrc(ID_alusrc),
    .EX_stall(EX_stall), .MEM_stall(MEM_stall), .EX_flush(EX_flush),
    .WB_rd(WB_rd), .WB_data(WB_data), .WB_regwrite(WB_regwrite),
    .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc), .ID_EX_imm(ID_EX_imm),
    .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
    .ID_EX_opcode(ID_EX_opcode), .ID_EX_funct3(ID_EX_funct3),
    .ID_EX_funct7b5(ID_EX_funct7b5), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2),
    .ID_EX_rd(ID_EX_rd), .ID_EX_regwrite(ID_EX_regwrite),
    .ID_EX_memread(ID_EX_memread), .ID_EX_memwrite(ID_EX_memwrite),
    .ID_EX_memtoreg(ID_EX_memtoreg), .ID_EX_branch(ID_EX_branch),
    .ID_EX_alusrc(ID_EX_alusrc), .ID_stall(ID_stall),
    .flush_pending(flush_pending), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [5:0]  ctrl;
    logic        fp;
    logic [15:0] bcnt;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  exp_t        e, o, cur;
  logic [15:0] exp_bcnt;

  // Decoded fields are derived from the pc so every instruction is distinguishable
  function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [5:0] ctrl, input logic fp, input logic [15:0] bc);
    exp_t r;
    r = '0;
    r.fp = fp;
    r.bcnt = bc;
    if (v) begin
      r.valid = 1'b1; r.pc = pc; r.opcode = pc[6:0] ^ 7'h33; r.funct3 = pc[2:0] ^ 3'h5;
      r.funct7b5 = ~pc[2]; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.imm = ~pc;
      r.d1 = d1; r.d2 = d2; r.ctrl = ctrl;
    end
    return r;
  endfunction

  function automatic exp_t sample();
    exp_t r;
    r.valid = ID_EX_valid; r.pc = ID_EX_pc; r.opcode = ID_EX_opcode;
    r.funct3 = ID_EX_funct3; r.funct7b5 = ID_EX_funct7b5; r.rs1 = ID_EX_rs1;
    r.rs2 = ID_EX_rs2; r.rd = ID_EX_rd; r.imm = ID_EX_imm; r.d1 = ID_EX_rs1_data;
    r.d2 = ID_EX_rs2_data;
    r.ctrl = {ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_memtoreg,
              ID_EX_branch, ID_EX_alusrc};
    r.fp = flush_pending; r.bcnt = bubble_count;
    return r;
  endfunction

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [5:0] ctrl);
    ID_valid = v; ID_pc = pc; ID_opcode = pc[6:0] ^ 7'h33; ID_funct3 = pc[2:0] ^ 3'h5;
    ID_funct7b5 = ~pc[2]; ID_imm = ~pc; ID_rs1 = rs1; ID_rs2 = rs2; ID_rd = rd;
    ID_rs1_data = d1; ID_rs2_data = d2;
    {ID_regwrite, ID_memread, ID_memwrite, ID_memtoreg, ID_branch, ID_alusrc} = ctrl;
  endtask

  task automatic wb_set(input logic en, input logic [4:0] rd, input logic [31:0] d);
    WB_regwrite = en; WB_rd = rd; WB_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] bump(input logic [15:0] c);
    return (c == 16'hFFFF) ? 16'hFFFF : c + 16'd1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; EX_stall = 0; MEM_stall = 0; EX_flush = 0;
    wb_set(0, 0, 0);
    set_id(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h1111, 32'h2222, 6'b100001);
    exp_bcnt = 16'd0;
    tick(); tick();
    o = sample(); total++;
    if (o !== exp_t'(0) || ID_stall !== 1'b0) begin
      bad++; $display("FAIL reset_state got=%h stall=%b exp=0", o, ID_stall);
    end
    rst_n = 1'b1;
    sb.push_back(mk(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h1111, 32'h2222, 6'b100001, 0, exp_bcnt));
    tick();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", o, e); end
    $display("reset release: pc=%h valid=%b", ID_EX_pc, ID_EX_valid);
    // freeze with a pending flush, then reset in the middle of the cycle
    MEM_stall = 1; EX_flush = 1;
    set_id(1, 32'h104, 5'd4, 5'd5, 5'd6, 32'h4, 32'h5, 6'b010000);
    cur = mk(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h1111, 32'h2222, 6'b100001, 1, exp_bcnt);
    sb.push_back(cur);
    tick();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_pre_hold got=%h exp=%h", o, e); end
    #2 rst_n = 1'b0;
    #1;
    exp_bcnt = 16'd0;
    o = sample(); total++;
    if (o !== exp_t'(0)) begin bad++; $display("FAIL reset_async got=%h exp=0", o); end
    MEM_stall = 0; EX_flush = 0;
    set_id(1, 32'h108, 5'd7, 5'd8, 5'd9, 32'h7, 32'h8, 6'b001100);
    tick();
    rst_n = 1'b1;
    sb.push_back(mk(1, 32'h108, 5'd7, 5'd8, 5'd9, 32'h7, 32'h8, 6'b001100, 0, exp_bcnt));
    tick();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_midstall got=%h exp=%h", o, e); end
    $display("reset mid-stall: pc=%h fp=%b bcnt=%0d", ID_EX_pc, flush_pending, bubble_count);
  endtask

  task automatic test_load_use();
    set_id(1, 32'h200, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 6'b100001);
    cur = mk(1, 32'h200, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 6'b100001, 0, exp_bcnt);
    sb.push_back(cur);
    tick();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL lu_load got=%h exp=%h", o, e); end
    EX_stall = 1;
    set_id(1, 32'h204, 5'd8, 5'd1, 5'd9, 32'h88, 32'h99, 6'b100000);
    wb_set(1, 5'd5, 32'hDEADBEEF);
    #1; total++;
    if (ID_stall !== 1'b1) begin bad++; $display("FAIL lu_id_stall got=%b exp=1", ID_stall); end
    cur.d1 = 32'hDEADBEEF;
    sb.push_back(cur);
    tick();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL lu_hold got=%h exp=%h", o, e); end
    $display("load-use hold: pc=%h rs1_data=%h", ID_EX_pc, ID_EX_rs1_data);
    EX_stall = 0; wb_set(0, 0, 0);
    #1; total++;
    if (ID_stall !== 1'b0) begin bad++; $display("FAIL lu_id_unstall got=%b exp=0", ID_stall); end
    sb.push_back(mk(1, 32'h204, 5'd8, 5'd1, 5'd9, 32'h88, 32'h99, 6'b100000, 0, exp_bcnt));
    tick();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL lu_release got=%h exp=%h", o, e); end
  endtask

  task automatic test_write_through();
    logic [4:0]  wrd [4];
    logic        wen [4];
    logic [4:0]  r1 [4];
    logic [4:0]  r2 [4];
    logic [31:0] x1 [4];
    logic [31:0] x2 [4];
    wrd = '{5'd7, 5'd0, 5'd7, 5'd9};       wen = '{1'b1, 1'b1, 1'b0, 1'b1};
    r1  = '{5'd3, 5'd0, 5'd3, 5'd9};       r2  = '{5'd7, 5'd7, 5'd7, 5'd9};
    x1  = '{32'h33, 32'h0, 32'h33, 32'h66}; x2  = '{32'h55, 32'h1, 32'h1, 32'h66};
    for (int i = 0; i < 4; i++) begin
      set_id(1, 32'h240 + 32'(i * 4), r1[i], r2[i], 5'd10,
             (r1[i] == 5'd0) ? 32'h0 : 32'h33, 32'h1, 6'b100010);
      wb_set(wen[i], wrd[i], (i == 3) ? 32'h66 : 32'h55);
      sb.push_back(mk(1, 32'h240 + 32'(i * 4), r1[i], r2[i], 5'd10, x1[i], x2[i],
                      6'b100010, 0, exp_bcnt));
      tick();
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL wt_case%0d got=%h exp=%h", i, o, e); end
      $display("write-through %0d: rs1_data=%h rs2_data=%h", i, ID_EX_rs1_data, ID_EX_rs2_data);
    end
    wb_set(0, 0, 0);
  endtask

  task automatic test_flush();
    set_id(1, 32'h280, 5'd4, 5'd4, 5'd11, 32'h40, 32'h41, 6'b111111);
    EX_flush = 1; EX_stall = 1;
    wb_set(1, 5'd4, 32'hAB);
    #1; total++;
    if (ID_stall !== 1'b0) begin bad++; $display("FAIL fl_id_stall got=%b exp=0", ID_stall); end
    exp_bcnt = bump(exp_bcnt);
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, exp_bcnt));
    tick();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL fl_bubble got=%h exp=%h", o, e); end
    $display("flush: valid=%b ctrl=%h bcnt=%0d", ID_EX_valid, o.ctrl, bubble_count);
    EX_flush = 0; EX_stall = 0; wb_set(0, 0, 0);
    sb.push_back(mk(1, 32'h280, 5'd4, 5'd4, 5'd11, 32'h40, 32'h41, 6'b111111, 0, exp_bcnt));
    tick();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL fl_reload got=%h exp=%h", o, e); end
  endtask

  task automatic test_mem_flush();
    set_id(1, 32'h300, 5'd3, 5'd3, 5'd12, 32'hA, 32'hB, 6'b110101);
    cur = mk(1, 32'h300, 5'd3, 5'd3, 5'd12, 32'hA, 32'hB, 6'b110101, 0, exp_bcnt);
    sb.push_back(cur);
    tick();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL mf_load got=%h exp=%h", o, e); end
    set_id(1, 32'h304, 5'd1, 5'd2, 5'd13, 32'h1, 32'h2, 6'b100000);
    MEM_stall = 1;
    for (int c = 0; c < 3; c++) begin
      EX_flush = (c == 0);
      if (c == 1) wb_set(1, 5'd3, 32'h77); else wb_set(0, 0, 0);
      #1; total++;
      if (ID_stall !== 1'b0) begin
        bad++; $display("FAIL mf_id_stall%0d got=%b exp=0", c, ID_stall);
      end
      cur.fp = 1'b1;
      if (c == 1) begin cur.d1 = 32'h77; cur.d2 = 32'h77; end
      sb.push_back(cur);
      tick();
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL mf_hold%0d got=%h exp=%h", c, o, e); end
      $display("mem-stall %0d: pc=%h fp=%b d1=%h d2=%h", c, ID_EX_pc, flush_pending,
               ID_EX_rs1_data, ID_EX_rs2_data);
    end
    MEM_stall = 0; EX_flush = 0; EX_stall = 1; wb_set(0, 0, 0);
    exp_bcnt = bump(exp_bcnt);
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, exp_bcnt));
    tick();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL mf_apply got=%h exp=%h", o, e); end
    EX_stall = 0;
    sb.push_back(mk(1, 32'h304, 5'd1, 5'd2, 5'd13, 32'h1, 32'h2, 6'b100000, 0, exp_bcnt));
    tick();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL mf_resume got=%h exp=%h", o, e); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      logic        v;
      logic [31:0] pc, a, b;
      logic [4:0]  s1, s2, d;
      logic [5:0]  ct;
      v = (i % 3) != 2;
      pc = 32'h400 + 32'(i * 4);
      a = $urandom; b = $urandom;
      s1 = 5'($urandom_range(1, 31)); s2 = 5'($urandom_range(1, 31)); d = 5'($urandom);
      ct = 6'($urandom);
      set_id(v, pc, s1, s2, d, a, b, ct);
      if (!v) exp_bcnt = bump(exp_bcnt);
      sb.push_back(mk(v, pc, s1, s2, d, a, b, ct, 0, exp_bcnt));
      tick();
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL b2b_%0d got=%h exp=%h", i, o, e); end
      $display("b2b %0d: valid=%b pc=%h bcnt=%0d", i, ID_EX_valid, ID_EX_pc, bubble_count);
    end
  endtask

  task automatic test_saturation();
    set_id(0, 32'h500, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 6'b111111);
    for (int i = 0; i < 65537; i++) begin
      exp_bcnt = bump(exp_bcnt);
      tick();
      if (i >= 65534) begin
        total++;
        if (bubble_count !== exp_bcnt || ID_EX_valid !== 1'b0) begin
          bad++;
          $display("FAIL sat_iter%0d got=%h exp=%h", i, bubble_count, exp_bcnt);
        end
      end
    end
    total++;
    if (bubble_count !== 16'hFFFF) begin
      bad++; $display("FAIL sat_final got=%h exp=ffff", bubble_count);
    end
    $display("saturation: bcnt=%h", bubble_count);
    set_id(1, 32'h600, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 6'b000001);
    sb.push_back(mk(1, 32'h600, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 6'b000001, 0, 16'hFFFF));
    tick();
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL sat_load got=%h exp=%h", o, e); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_write_through();
    test_flush();
    test_mem_flush();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_register.md
# id_ex_pipeline_register

Pipeline register between the ID stage and the EX stage of the 5-stage RISC-V core. It captures decoded fields, operands and control bits from ID and presents them to the ALU and to the EX hazard checker (as ID_EX_rs1/ID_EX_rs2). It freezes on EX or MEM stalls and becomes a bubble on branch flushes. While frozen, it snoops register-file writeback so that held operands never go stale.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ID_valid  in  1  ID holds a real instruction
- ID_pc  in  32  instruction PC
- ID_opcode  in  7  opcode field
- ID_funct3  in  3  funct3 field
- ID_funct7b5  in  1  instruction bit 30
- ID_rs1, ID_rs2, ID_rd  in  5 each  register indices
- ID_rs1_data, ID_rs2_data  in  32 each  register-file read data
- ID_imm  in  32  sign-extended immediate
- ID_regwrite, ID_memread, ID_memwrite, ID_memtoreg, ID_branch, ID_alusrc  in  1 each  decoded control bits
- EX_stall  in  1  load-use stall from the EX hazard checker
- MEM_stall  in  1  data-memory wait; the whole pipeline freezes
- EX_flush  in  1  taken branch/jump; kill the instruction in ID
- WB_rd  in  5  writeback destination
- WB_data  in  32  writeback value
- WB_regwrite  in  1  writeback enable
- ID_EX_valid  out  1  registered valid
- ID_EX_pc, ID_EX_imm, ID_EX_rs1_data, ID_EX_rs2_data  out  32 each  registered copies
- ID_EX_opcode  out  7;  ID_EX_funct3  out  3;  ID_EX_funct7b5  out  1
- ID_EX_rs1, ID_EX_rs2, ID_EX_rd  out  5 each
- ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_memtoreg, ID_EX_branch, ID_EX_alusrc  out  1 each
- ID_stall  out  1  hold request to the IF/ID register and PC
- flush_pending  out  1  flush captured during MEM_stall, not yet applied
- bubble_count  out  16  saturating count of bubbles loaded

## Operation
- Bubble definition: valid=0, rd=rs1=rs2=0, all six control bits 0, other fields 0.
- Per-edge action priority:
  - If rst_n=0: reset.
  - Else if MEM_stall: full hold. If EX_flush, set flush_pending.
  - Else if EX_flush or flush_pending: load a bubble and clear flush_pending.
  - Else if EX_stall: hold.
  - Else: load from ID. If ID_valid=0, load a bubble instead.
- Load path write-through: if WB_regwrite, WB_rd!=0 and WB_rd==ID_rs1, capture WB_data instead of ID_rs1_data. rs2 behaves the same way.
- Hold path refresh: while holding (MEM_stall or EX_stall), if WB_regwrite, WB_rd!=0, WB_rd==ID_EX_rs1 and ID_EX_valid, then ID_EX_rs1_data<=WB_data. rs2 behaves the same way. All other fields are unchanged.
- ID_stall = (EX_stall | MEM_stall) & ~(EX_flush | flush_pending). This is combinational. IF/ID must not hold on a flush cycle.
- bubble_count increments on every edge that loads a bubble, from either a flush or ID_valid=0. Holds never increment it. It saturates at 16'hFFFF and clears only on reset.
- x0 is never forwarded or refreshed. Reads of index 0 keep the register-file value (0).

## Timing
- Latency: ID inputs appear on ID_EX outputs one rising edge after capture.
- Reset (asynchronous assert, synchronous release at the next edge): all outputs 0, i.e. a bubble, flush_pending=0, bubble_count=0.
- Reset mid-stall discards the held instruction and any pending flush.
- EX_stall lasting one cycle holds the same instruction for exactly two consecutive cycles in EX.
- A flush during MEM_stall takes effect on the first edge with MEM_stall=0, even if EX_stall is also high at that edge.
- A flush and a WB match in the same cycle: the bubble wins. No refresh is applied to a bubble.
- Simultaneous hold and WB write to both rs1 and rs2 (same index): both data outputs update.

## Test plan
- Reset: drive rst_n=0 mid-run. All outputs are 0 immediately, without waiting for a clock edge. After release, ID_valid=1 with pc=0x100 gives ID_EX_pc=0x100 and valid=1 one edge later.
- Load-use: EX_stall=1 for one cycle with rs1=5 held. The same ID_EX_pc is seen for 2 cycles and ID_stall=1 during the stall. A WB write (rd=5, data=0xDEADBEEF) during the hold gives ID_EX_rs1_data=0xDEADBEEF.
- Write-through: ID_rs2=7, ID_rs2_data=0x1, WB_rd=7, WB_data=0x55 in the same cycle. Expect ID_EX_rs2_data=0x55. With WB_rd=0 instead, expect 0x1.
- Flush: EX_flush=1 with ID_valid=1. Next cycle all control bits are 0, valid=0, and bubble_count increments by 1.
- Flush under MEM_stall: EX_flush pulses while MEM_stall=1 for 3 cycles. flush_pending=1 and the outputs are frozen. On the first edge with MEM_stall=0 a bubble is loaded and flush_pending returns to 0.
- Saturation: force 65537 bubble loads. bubble_count stays at 16'hFFFF.
